// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, latched operation, LFSR seed.
// Pure declarations; no latency or backpressure of its own.
package mem_resp_types;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

    typedef enum logic [1:0] {op_none, op_rd, op_wr} mem_op_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/mem_responder_ram.sv
// DEPTH x 32 word store with per-byte-lane synchronous write and combinational read.
// Zero-latency read of i_idx; write lands at the next clk edge; no backpressure.
module resp_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: answers a held mem_read/mem_write with a one-cycle mem_resp LATENCY cycles later.
// Requester must hold the request until mem_resp; MEM_RAND_LAT_EN makes the latency LFSR-driven per transaction.
module mem_responder
    import mem_resp_types::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH);

    mem_resp_state_t r_state;
    mem_op_t         r_op;
    logic [AW-1:0]   r_idx;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [3:0]      r_cnt;
    logic            r_resp;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_rd_req;
    logic            w_wr_req;
    logic            w_accept;
    logic [3:0]      w_lat_m1;
    logic            w_enter_resp;
    logic            w_is_wr;
    logic            w_we;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ram_rdata;
    logic            w_unused_addr;

    assign w_rd_req = mem_read & ~mem_write;
    assign w_wr_req = mem_write & ~mem_read;
    assign w_accept = (r_state == IDLE) && (w_rd_req || w_wr_req);

`ifdef MEM_RAND_LAT_EN
    localparam logic [4:0] LAT5 = 5'(LATENCY);
    logic [7:0] r_lfsr;

    assign w_lat_m1 = 4'({1'b0, r_lfsr[3:0]} % LAT5);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`else
    assign w_lat_m1 = 4'(LATENCY - 1);
`endif

    // With a one-cycle latency the RAM is accessed straight from the bus in IDLE,
    // otherwise from the values latched when the request was accepted.
    assign w_idx   = (r_state == IDLE) ? mem_address[AW+1:2] : r_idx;
    assign w_be    = (r_state == IDLE) ? mem_byte_enable     : r_be;
    assign w_wdata = (r_state == IDLE) ? mem_wdata           : r_wdata;
    assign w_is_wr = (r_state == IDLE) ? w_wr_req            : (r_op == op_wr);

    assign w_enter_resp = (w_accept && (w_lat_m1 == 4'd0)) ||
                          ((r_state == WAIT) && (mem_read || mem_write) && (r_cnt == 4'd1));
    assign w_we = w_enter_resp && w_is_wr;

    assign w_unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};

    resp_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_op    <= op_none;
            r_idx   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_op    <= w_rd_req ? op_rd : op_wr;
                        r_idx   <= mem_address[AW+1:2];
                        r_be    <= mem_byte_enable;
                        r_wdata <= mem_wdata;
                        r_cnt   <= w_lat_m1;
                        if (w_lat_m1 == 4'd0) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                            if (w_rd_req) r_rdata <= w_ram_rdata;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_read && !mem_write) begin
                        r_state <= IDLE;
                        r_op    <= op_none;
                        r_err   <= 1'b1;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (r_op == op_rd) r_rdata <= w_ram_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_op    <= op_none;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = r_resp;
    assign proto_err = r_err;

endmodule
